datamem_stream_reader: RTL
==========================

Name: datamem_stream_reader

Overview:
- Read-side sequencer placed directly downstream of the 512x16 data memory.
- On a start command it issues a contiguous run of read addresses to the memory, which has 1-cycle registered read latency.
- It buffers the returned words and presents them as a valid/ready stream to the MAC datapath, with full throughput and lossless backpressure.

Parameters:
- ADDR_W, 9: memory address width (512 words).
- DATA_W, 16: word width.
- LEN_W, 10: transfer length width; legal len range is 0..512.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only while idle.
- base_addr  input  ADDR_W  first word address; captured when start is accepted.
- len  input  LEN_W  number of words to stream; captured when start is accepted.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at the end of a transfer.
- mem_raddr  output  ADDR_W  read address to the memory; registered.
- mem_rdata  input  DATA_W  memory read data; valid 1 cycle after the address was presented.
- m_valid  output  1  stream word valid.
- m_data  output  DATA_W  stream word.
- m_last  output  1  marks the final word of the transfer; only meaningful when m_valid is high.
- m_ready  input  1  consumer accepts a word.

Behaviour:
- Reset (rst=1 at a clock edge):
  - busy=0, done=0, m_valid=0, m_last=0, m_data=0, mem_raddr=0.
  - FIFO and all counters cleared; state=IDLE.
  - Any in-flight read is discarded. rst overrides all other inputs, including mid-transfer.
- States:
  - IDLE: start=1 captures base_addr/len, loads mem_raddr=base_addr, issue_cnt=0, beat_cnt=0. Go to RUN if len!=0, else to FIN.
  - RUN: issue reads and deliver beats. Go to FIN on the edge where the final beat (m_last & m_ready) is accepted.
  - FIN: assert done for one cycle, busy=0, then return to IDLE.
- start while busy is ignored. len>512 is illegal and its behaviour is unspecified.
- Issue:
  - A read is issued in a cycle when state=RUN, issue_cnt<len, and (fifo_cnt + inflight - pop) < 2. Here pop = m_valid & m_ready.
  - On issue: inflight<=1 and mem_raddr<=mem_raddr+1, mod 512. Address wraps 511->0.
  - No issue means mem_raddr holds.
- Return: when inflight=1, mem_rdata is pushed into a 2-entry FIFO at the next edge. Capacity is guaranteed by the issue rule, so the FIFO never overflows.
- Output:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - m_last = (beat_cnt == len-1) & m_valid.
  - m_valid/m_data are stable while m_valid & !m_ready; no word is ever dropped or duplicated.
- Latency:
  - start sampled at edge E0; busy=1 after E0, and mem_raddr=base_addr is driven in cycle 1.
  - Data lands in the FIFO at E2; m_valid=1 in cycle 3.
  - With m_ready held high: one word per cycle, and len words complete in len+3 cycles from start.
- done timing:
  - Asserted in the cycle after the last beat is accepted; busy is low in that same cycle.
  - For len=0, done is asserted the cycle after start with no beats, and busy stays 0.
- Simultaneous events: push and pop in the same cycle leave fifo_cnt unchanged. The issue rule counts the same-cycle pop.

Test Plan:
- Memory preloaded with mem[k]=16'h1000+k. Apply start, base=5, len=4, m_ready=1 -> m_data 1005,1006,1007,1008 on consecutive cycles starting 3 cycles after start. m_last on 1008; done pulse one cycle later.
- base=510, len=4 -> mem_raddr sequence 510,511,0,1; data 11FE,11FF,1000,1001.
- len=8, m_ready toggling 1,0,0,1,... -> all 8 words arrive in order with none lost or repeated. m_data holds while stalled, and mem_raddr stops advancing while FIFO+inflight=2.
- len=0 -> no m_valid; done=1 exactly the cycle after start; busy never asserts.
- rst=1 asserted in the middle of a len=16 transfer after 5 beats -> next cycle all outputs are at reset values. A fresh start with base=0, len=2 then yields 1000,1001 only.
- start pulsed again while busy (base=100) -> ignored; the original transfer completes unchanged.

Source files
------------

// File: rtl/datamem_stream_reader.sv
// Read sequencer for the 512x16 data memory: issues a contiguous address run and
// re-times the 1-cycle registered read data into a 2-deep valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start; base/len captured on start
// RUN   | issuing reads and delivering beats
// FIN   | one-cycle done pulse, then back to IDLE
module datamem_stream_reader #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t            state;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issue_cnt;
   logic [LEN_W-1:0]  beat_cnt;
   logic              inflight;
   logic [DATA_W-1:0] fifo_mem [2];
   logic              fifo_rd_ptr;
   logic              fifo_wr_ptr;
   logic [1:0]        fifo_cnt;
   logic [1:0]        occupancy;
   logic              pop;
   logic              issue;

   assign m_valid = (fifo_cnt != 2'd0);
   assign m_data  = fifo_mem[fifo_rd_ptr];
   assign m_last  = m_valid && (beat_cnt == len_q - LEN_W'(1));
   assign pop     = m_valid && m_ready;

   // FIFO fill once this cycle's returning word and this cycle's pop have landed
   assign occupancy = fifo_cnt + {1'b0, inflight} - {1'b0, pop};
   assign issue     = (state == S_RUN) && (issue_cnt < len_q) && (occupancy < 2'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_raddr   <= '0;
         len_q       <= '0;
         issue_cnt   <= '0;
         beat_cnt    <= '0;
         inflight    <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         fifo_rd_ptr <= 1'b0;
         fifo_wr_ptr <= 1'b0;
         fifo_cnt    <= 2'd0;
      end else begin
         inflight <= issue;
         done     <= 1'b0;
         fifo_cnt <= occupancy;

         if (issue) begin
            mem_raddr <= mem_raddr + ADDR_W'(1);
            issue_cnt <= issue_cnt + LEN_W'(1);
         end
         if (inflight) begin
            fifo_mem[fifo_wr_ptr] <= mem_rdata;
            fifo_wr_ptr           <= ~fifo_wr_ptr;
         end
         if (pop) begin
            fifo_rd_ptr <= ~fifo_rd_ptr;
            beat_cnt    <= beat_cnt + LEN_W'(1);
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  len_q     <= len;
                  mem_raddr <= base_addr;
                  issue_cnt <= '0;
                  beat_cnt  <= '0;
                  if (len != '0) begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                  end else begin
                     state <= S_FIN;
                     done  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (pop && m_last) begin
                  state <= S_FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
